// File: rtl/stage_4_mem_access_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
// Covers the size codes, the FSM states, byte-lane enables, store replication and load extension.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Copy the low bytes into every lane so the byte enables alone pick the destination.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    lanes = data;
    case (size)
      SZ_BYTE: lanes = {4{data[7:0]}};
      SZ_HALF: lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    b      = word[{off, 3'b000} +: 8];
    h      = word[{off[1], 4'b0000} +: 16];
    result = word;
    case (size)
      SZ_BYTE: result = {{24{~uns & b[7]}}, b};
      SZ_HALF: result = {{16{~uns & h[15]}}, h};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/stage_4_mem_access_data_ram.sv
// Single-port data RAM with per-byte write enables and a registered read port.
// The storage array is deliberately not reset.
module data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stage_4_mem_access.sv
// MEM pipeline stage: validates load/store requests, sequences a multi-cycle RAM access
// with a stall handshake, steers store lanes and aligns/extends load data.
module stage_4_mem_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg_data_2,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              stall,
  output logic              done,
  output logic              access_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANES  = DATA_W / 8;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [DATA_W-3:0] DEPTH_LIMIT = (DATA_W - 2)'(DEPTH);

  state_t              state;
  logic [CNT_W-1:0]    counter;
  logic [ADDR_W-1:0]   index_q;
  logic [1:0]          offset_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic                store_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                request;
  logic                reject;
  logic                complete;
  logic [ADDR_W-1:0]   ram_addr;
  logic [LANES-1:0]    ram_be;
  logic [DATA_W-1:0]   ram_rdata;

  assign request  = memread | memwrite;
  assign reject   = (memread & memwrite)
                  | (mem_size == 2'b11)
                  | ((mem_size == SZ_HALF) & alu_result[0])
                  | ((mem_size == SZ_WORD) & (alu_result[1:0] != 2'b00))
                  | (alu_result[DATA_W-1:2] >= DEPTH_LIMIT);
  assign stall    = ((state == IDLE) & request & ~reject) | (state == BUSY);
  assign complete = (state == BUSY) && (counter == CNT_W'(1));

  // While idle the RAM reads the incoming address so load data is ready even when LATENCY is 1.
  assign ram_addr = (state == IDLE) ? alu_result[ADDR_W+1:2] : index_q;
  assign ram_be   = (complete && store_q && reset_n) ? lane_enable(size_q, offset_q) : '0;

  data_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      counter       <= '0;
      mem_read_data <= '0;
      done          <= 1'b0;
      access_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            if (reject) begin
              access_err <= 1'b1;
            end else begin
              index_q    <= alu_result[ADDR_W+1:2];
              offset_q   <= alu_result[1:0];
              size_q     <= mem_size;
              unsigned_q <= mem_unsigned;
              store_q    <= memwrite;
              wdata_q    <= store_lanes(mem_size, reg_data_2);
              counter    <= CNT_W'(LATENCY);
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            if (!store_q) mem_read_data <= load_extend(ram_rdata, offset_q, size_q, unsigned_q);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
